mem_burst_scheduler: RTL and testbench

- Shares the single external-memory burst engine between the warp requester and the framebuffer requester.
- Accepts whole-transfer requests (address, total beats, read/write) from each requester and arbitrates between them.
- Splits each granted transfer into bursts of at most MAX_BURSTS beats, issues them one at a time on a command channel, and signals per-requester completion.
- Sits between the warp/fb memory-manager connections and the AXI master engine.

---
 rtl/mem_burst_scheduler.sv | 131 +++++++++++++
 tb/tb_mem_burst_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_scheduler.sv
// Arbitrates warp/framebuffer transfer requests and splits each into bursts for the AXI engine.
// Define MEM_SCHED_WARP_PRIORITY_EN for fixed warp priority; otherwise round-robin.
module mem_burst_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURSTS = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  warp_req_valid,
  output logic                  warp_req_ready,
  input  logic                  warp_req_write,
  input  logic [ADDR_WIDTH-1:0] warp_req_addr,
  input  logic [LEN_WIDTH-1:0]  warp_req_len,
  output logic                  warp_done,
  input  logic                  fb_req_valid,
  output logic                  fb_req_ready,
  input  logic                  fb_req_write,
  input  logic [ADDR_WIDTH-1:0] fb_req_addr,
  input  logic [LEN_WIDTH-1:0]  fb_req_len,
  output logic                  fb_done,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic                  cmd_src,
  input  logic                  burst_done,
  output logic                  busy
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  write_q, write_d;
  logic                  src_q, src_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;

  logic                  grant_fb;
  logic                  accept;
  logic [LEN_WIDTH-1:0]  beats;

  // Source select: 0 = warp, 1 = fb.
  always_comb begin
    grant_fb = fb_req_valid;
    if (warp_req_valid && fb_req_valid) begin
`ifdef MEM_SCHED_WARP_PRIORITY_EN
      grant_fb = 1'b0;
`else
      grant_fb = ~last_grant_q;
`endif
    end
  end

  assign accept         = (state_q == IDLE) && enable && (warp_req_valid || fb_req_valid);
  assign warp_req_ready = accept && !grant_fb;
  assign fb_req_ready   = accept && grant_fb;

  assign beats = (rem_q > LEN_WIDTH'(MAX_BURSTS)) ? LEN_WIDTH'(MAX_BURSTS) : rem_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    src_d        = src_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d        = grant_fb;
          last_grant_d = grant_fb;
          write_d      = grant_fb ? fb_req_write : warp_req_write;
          addr_d       = grant_fb ? fb_req_addr  : warp_req_addr;
          rem_d        = grant_fb ? fb_req_len   : warp_req_len;
          state_d      = ((grant_fb ? fb_req_len : warp_req_len) != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          rem_d   = rem_q - beats;
          addr_d  = addr_q + (ADDR_WIDTH'(beats) << BEAT_SHIFT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (burst_done) begin
          state_d = (rem_q != '0) ? ISSUE : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command fields are forced to zero outside ISSUE so idle outputs are clean.
  assign cmd_valid = (state_q == ISSUE);
  assign cmd_write = cmd_valid & write_q;
  assign cmd_src   = cmd_valid & src_q;
  assign cmd_addr  = cmd_valid ? addr_q : '0;
  assign cmd_len   = cmd_valid ? 8'(beats - LEN_WIDTH'(1)) : 8'd0;
  assign warp_done = (state_q == DONE) & ~src_q;
  assign fb_done   = (state_q == DONE) & src_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      src_q        <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Directed bench for mem_burst_scheduler: transaction-level burst-plan model plus literal pins.
module tb_mem_burst_scheduler;

  localparam int AW = 32, DW = 128, MAXB = 256, LW = 16, BPB = DW / 8;
  localparam int BD_DLY = 4;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic          warp_req_valid, warp_req_ready, warp_req_write, warp_done;
  logic [AW-1:0] warp_req_addr;
  logic [LW-1:0] warp_req_len;
  logic          fb_req_valid, fb_req_ready, fb_req_write, fb_done;
  logic [AW-1:0] fb_req_addr;
  logic [LW-1:0] fb_req_len;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_src, burst_done, busy;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;

  always #5 clk = ~clk;

  mem_burst_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURSTS(MAXB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .warp_req_valid(warp_req_valid), .warp_req_ready(warp_req_ready), .warp_req_write(warp_req_write),
    .warp_req_addr(warp_req_addr), .warp_req_len(warp_req_len), .warp_done(warp_done),
    .fb_req_valid(fb_req_valid), .fb_req_ready(fb_req_ready), .fb_req_write(fb_req_write),
    .fb_req_addr(fb_req_addr), .fb_req_len(fb_req_len), .fb_done(fb_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_src(cmd_src), .burst_done(burst_done), .busy(busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } cmd_t;

  int   vectors = 0, miscompares = 0;
  cmd_t m_q[$];
  cmd_t cmd_log[$];
  bit   grant_log[$];
  int   m_phase = 0;   // 0 idle, 1 command pending, 2 awaiting burst end, 3 done pulse
  bit   m_src, m_write, m_last = 1'b1;
  int   warp_done_cnt = 0, fb_done_cnt = 0;
  bit   chk_en = 1'b0;
  bit   hs_neg = 1'b0;
  int   eng_cnt = 0;

  function automatic bit pick_fb(input bit wv, input bit fv, input bit last);
    if (wv && fv) begin
`ifdef MEM_SCHED_WARP_PRIORITY_EN
      return 1'b0;
`else
      return ~last;
`endif
    end
    return fv;
  endfunction

  // Expected burst list of a whole transfer.
  task automatic plan(input logic [31:0] a0, input logic [15:0] len);
    int r;
    logic [31:0] a;
    r = int'(len);
    a = a0;
    while (r > 0) begin
      int b;
      cmd_t c;
      b = (r > MAXB) ? MAXB : r;
      c.a = a;
      c.l = 8'(b - 1);
      m_q.push_back(c);
      a = a + 32'(b * BPB);
      r = r - b;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model update at each active edge
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_q.delete();
    end else begin
      case (m_phase)
        0: if (enable && (warp_req_valid || fb_req_valid)) begin
             m_src   = pick_fb(warp_req_valid, fb_req_valid, m_last);
             m_write = m_src ? fb_req_write : warp_req_write;
             plan(m_src ? fb_req_addr : warp_req_addr, m_src ? fb_req_len : warp_req_len);
             m_last  = m_src;
             m_phase = (m_q.size() == 0) ? 3 : 1;
           end
        1: if (cmd_ready) begin
             void'(m_q.pop_front());
             m_phase = 2;
           end
        2: if (burst_done) m_phase = (m_q.size() == 0) ? 3 : 1;
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare and observation log
  initial forever begin
    logic [47:0] exp_v, act_v;
    bit e_cv, e_acc, e_fb;
    @(negedge clk);
    hs_neg = cmd_valid && cmd_ready;
    if (chk_en) begin
      e_cv  = (m_phase == 1);
      e_acc = (m_phase == 0) && enable && (warp_req_valid || fb_req_valid);
      e_fb  = pick_fb(warp_req_valid, fb_req_valid, m_last);
      exp_v = {m_phase != 0, e_cv, e_cv & m_write, e_cv & m_src,
               e_cv ? m_q[0].a : 32'h0, e_cv ? m_q[0].l : 8'h0,
               e_acc & ~e_fb, e_acc & e_fb, (m_phase == 3) & ~m_src, (m_phase == 3) & m_src};
      act_v = {busy, cmd_valid, cmd_write, cmd_src, cmd_addr, cmd_len,
               warp_req_ready, fb_req_ready, warp_done, fb_done};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle t=%0t {busy,cv,cw,cs,addr,len,wr,fr,wd,fd} actual=%h expected=%h",
                 $time, act_v, exp_v);
      end
      if (cmd_valid && cmd_ready) begin
        cmd_t c;
        c.a = cmd_addr;
        c.l = cmd_len;
        cmd_log.push_back(c);
      end
      if (warp_req_valid && warp_req_ready) grant_log.push_back(1'b0);
      if (fb_req_valid && fb_req_ready)     grant_log.push_back(1'b1);
      if (warp_done) warp_done_cnt++;
      if (fb_done)   fb_done_cnt++;
    end
  end

  // Engine: burst_done sampled BD_DLY edges after each command handshake
  initial forever begin
    bit hs;
    @(posedge clk);
    hs = hs_neg;
    #1;
    burst_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) burst_done = 1'b1;
    end
    if (hs) eng_cnt = BD_DLY - 1;
  end

  task automatic req(input bit fb, input bit wr, input logic [31:0] a, input logic [15:0] l);
    bit got = 1'b0;
    if (fb) begin
      fb_req_write = wr; fb_req_addr = a; fb_req_len = l; fb_req_valid = 1'b1;
    end else begin
      warp_req_write = wr; warp_req_addr = a; warp_req_len = l; warp_req_valid = 1'b1;
    end
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (fb ? fb_req_ready : warp_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(fb ? "fb_accept_timeout" : "warp_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (fb) fb_req_valid = 1'b0;
    else    warp_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(nm, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int base, wbase, fbase;
    rst = 1'b1; enable = 1'b1; cmd_ready = 1'b1; burst_done = 1'b0;
    warp_req_valid = 1'b0; warp_req_write = 1'b0; warp_req_addr = '0; warp_req_len = '0;
    fb_req_valid = 1'b0; fb_req_write = 1'b0; fb_req_addr = '0; fb_req_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 64'({busy, cmd_valid, cmd_write, cmd_src, cmd_addr, cmd_len,
                              warp_req_ready, fb_req_ready, warp_done, fb_done}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both requesters valid after reset: warp wins the first tie
    base = grant_log.size();
    fork
      req(1'b0, 1'b0, 32'h100, 16'd1);
      req(1'b1, 1'b0, 32'h200, 16'd1);
    join
    wait_idle("idle_timeout_tie1");
    chk("tie1_count", 64'(grant_log.size() - base), 64'd2);
    chk("tie1_first", 64'(grant_log[base]), 64'd0);
    chk("tie1_second", 64'(grant_log[base+1]), 64'd1);

    // Warp re-requests immediately while fb waits
    base = grant_log.size();
    fork
      begin
        req(1'b0, 1'b0, 32'h300, 16'd1);
        req(1'b0, 1'b0, 32'h400, 16'd1);
      end
      req(1'b1, 1'b0, 32'h500, 16'd1);
    join
    wait_idle("idle_timeout_tie2");
    chk("tie2_count", 64'(grant_log.size() - base), 64'd3);
`ifdef MEM_SCHED_WARP_PRIORITY_EN
    chk("tie2_order", 64'({grant_log[base], grant_log[base+1], grant_log[base+2]}), 64'b001);
`else
    chk("tie2_order", 64'({grant_log[base], grant_log[base+1], grant_log[base+2]}), 64'b010);
`endif

    // Warp read of 600 beats from 0x1000
    base = cmd_log.size(); wbase = warp_done_cnt;
    req(1'b0, 1'b0, 32'h1000, 16'd600);
    wait_idle("idle_timeout_600");
    chk("t600_count", 64'(cmd_log.size() - base), 64'd3);
    chk("t600_b0", 64'({cmd_log[base].a, cmd_log[base].l}), 64'({32'h1000, 8'd255}));
    chk("t600_b1", 64'({cmd_log[base+1].a, cmd_log[base+1].l}), 64'({32'h2000, 8'd255}));
    chk("t600_b2", 64'({cmd_log[base+2].a, cmd_log[base+2].l}), 64'({32'h3000, 8'd87}));
    chk("t600_done", 64'(warp_done_cnt - wbase), 64'd1);

    // Zero-length fb write: done without any command
    base = cmd_log.size(); fbase = fb_done_cnt;
    req(1'b1, 1'b1, 32'h500, 16'd0);
    wait_idle("idle_timeout_len0");
    chk("len0_no_cmd", 64'(cmd_log.size() - base), 64'd0);
    chk("len0_done", 64'(fb_done_cnt - fbase), 64'd1);

    // Backpressure for 10 cycles on the first burst
    base = cmd_log.size();
    cmd_ready = 1'b0;
    req(1'b1, 1'b0, 32'h40, 16'd300);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_no_handshake", 64'(cmd_log.size() - base), 64'd0);
    cmd_ready = 1'b1;
    wait_idle("idle_timeout_bp");
    chk("bp_count", 64'(cmd_log.size() - base), 64'd2);
    chk("bp_b0", 64'({cmd_log[base].a, cmd_log[base].l}), 64'({32'h40, 8'd255}));
    chk("bp_b1", 64'({cmd_log[base+1].a, cmd_log[base+1].l}), 64'({32'h1040, 8'd43}));

    // Enable low holds off acceptance; then address wrap
    base = cmd_log.size(); wbase = grant_log.size();
    enable = 1'b0;
    fork
      req(1'b0, 1'b1, 32'hFFFF_FF00, 16'd512);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("enable_blocks", 64'(grant_log.size() - wbase), 64'd0);
        enable = 1'b1;
      end
    join
    wait_idle("idle_timeout_wrap");
    chk("wrap_b0", 64'({cmd_log[base].a, cmd_log[base].l}), 64'({32'hFFFF_FF00, 8'd255}));
    chk("wrap_b1", 64'({cmd_log[base+1].a, cmd_log[base+1].l}), 64'({32'h0000_0F00, 8'd255}));

    // Reset while waiting on the first burst of a 3-burst transfer
    base = cmd_log.size(); wbase = warp_done_cnt;
    req(1'b0, 1'b0, 32'h8000, 16'd600);
    for (int i = 0; i < LIMIT && cmd_log.size() == base; i++) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", 64'({busy, cmd_valid, warp_done, fb_done, cmd_addr, cmd_len}), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_more_cmds", 64'(cmd_log.size() - base), 64'd1);
    chk("rst_no_done", 64'(warp_done_cnt - wbase), 64'd0);
    req(1'b0, 1'b0, 32'h9000, 16'd2);
    wait_idle("idle_timeout_after_rst");
    chk("post_rst_cmd", 64'({cmd_log[cmd_log.size()-1].a, cmd_log[cmd_log.size()-1].l}),
        64'({32'h9000, 8'd1}));
    chk("post_rst_done", 64'(warp_done_cnt - wbase), 64'd1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
